uart_burst_rx: RTL

//  Receive side matching the burst-capable UART transmitter: deserializes 8N1 frames from rxd and

---
 rtl/uart_burst_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_burst_rx.sv
// 8N1 UART receiver delivering 32-bit words: one zero-extended byte per word in normal mode,
// or four LSB-first bytes per word in burst mode, with framing, overrun and burst-timeout flags.
module uart_burst_rx #(
  parameter int BAUDBITS = 9,
  parameter int IDLEBITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [31:0] d,
  input  logic        wrbaud,
  input  logic        rd,
  output logic [31:0] q,
  output logic        dv,
  output logic        fe,
  output logic        ove,
  output logic        tmo
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int IW = $clog2(IDLEBITS + 1);

  state_t              state_q, state_d;
  logic [1:0]          sync;
  logic [1:0]          warm;
  logic                armed;
  logic                rx_s, fall, tick;
  logic                load_half, shift, byte_done;
  logic [BAUDBITS-1:0] divider, divrx;
  logic                mode;
  logic [7:0]          shreg;
  logic [2:0]          bitcnt;
  logic [1:0]          cnt;
  logic [31:0]         shadow, merged, word;
  logic                word_fe, merged_fe, wfe, word_done;
  logic [IW-1:0]       idle_cnt;
  logic                timeout_hit;
  logic                unused_d;

  assign unused_d = &{1'b0, d[30:BAUDBITS]};

  // Edge is taken one stage early so that a 1-clk/bit start bit is still sampled low in START.
  // The line only counts as armed after a real (post-reset) high has reached the second flop,
  // so the reset value of the synchronizer cannot fake a falling edge mid-frame.
  assign rx_s = sync[1];
  assign fall = armed & sync[1] & ~sync[0];
  assign tick = (divrx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      // NOTE: every sequential block uses non-blocking assignments so all flops update together.
      sync  <= {sync[0], rxd};
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & sync[1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            divrx <= '0;
    else if (load_half) divrx <= divider >> 1;
    else if (tick)      divrx <= divider;
    else                divrx <= divrx - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d   = state_q;
    load_half = 1'b0;
    shift     = 1'b0;
    byte_done = 1'b0;
    case (state_q)
      IDLE:  if (fall) begin
               load_half = 1'b1;
               state_d   = START;
             end
      START: if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:  if (tick) begin
               shift = 1'b1;
               if (bitcnt == 3'd7) state_d = STOP;
             end
      STOP:  if (tick) begin
               byte_done = 1'b1;
               if (fall) begin
                 load_half = 1'b1;
                 state_d   = START;
               end else begin
                 state_d = IDLE;
               end
             end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= {rx_s, shreg[7:1]};
      bitcnt <= bitcnt + 1'b1;
    end else if (state_q != DATA) begin
      bitcnt <= '0;
    end
  end

  always_comb begin
    merged                     = shadow;
    merged[{cnt, 3'b000} +: 8] = shreg;
  end

  assign merged_fe   = word_fe | ~rx_s;
  assign word        = mode ? merged : {24'h0, shreg};
  assign wfe         = mode ? merged_fe : ~rx_s;
  assign word_done   = byte_done & (~mode | (cnt == 2'd3));
  assign timeout_hit = mode & (state_q == IDLE) & (cnt != 2'd0) & tick & ~fall &
                       (idle_cnt == IW'(IDLEBITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider  <= '0;
      mode     <= 1'b0;
      cnt      <= '0;
      shadow   <= '0;
      word_fe  <= 1'b0;
      idle_cnt <= '0;
      q        <= '0;
      fe       <= 1'b0;
      dv       <= 1'b0;
      ove      <= 1'b0;
      tmo      <= 1'b0;
    end else begin
      if (wrbaud) begin
        divider <= d[BAUDBITS-1:0];
        mode    <= d[31];
      end

      // Lanes build up in shadow so q only moves when a whole word is ready.
      if (wrbaud || timeout_hit) begin
        cnt     <= '0;
        shadow  <= '0;
        word_fe <= 1'b0;
      end else if (byte_done && mode) begin
        if (cnt == 2'd3) begin
          cnt     <= '0;
          shadow  <= '0;
          word_fe <= 1'b0;
        end else begin
          cnt     <= cnt + 1'b1;
          shadow  <= merged;
          word_fe <= merged_fe;
        end
      end

      if (fall || cnt == 2'd0 || timeout_hit)        idle_cnt <= '0;
      else if (mode && state_q == IDLE && tick)       idle_cnt <= idle_cnt + 1'b1;

      if (word_done) begin
        q   <= word;
        fe  <= wfe;
        dv  <= 1'b1;
        ove <= dv & ~rd;
      end else if (rd) begin
        dv  <= 1'b0;
        ove <= 1'b0;
      end

      if (timeout_hit) tmo <= 1'b1;
      else if (rd)     tmo <= 1'b0;
    end
  end

endmodule
